// File: rtl/wb_port_arbiter_if.sv
// Bundle of the WB-stage, MDU-result and register-file write signals around wb_port_arbiter.
// The arbiter uses the slave modport; the pipeline/MDU/regfile side uses the master modport.
interface wb_port_arbiter_if;
    logic        wb_valid;
    logic [1:0]  wb_sel;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu;
    logic [31:0] wb_mem;
    logic [31:0] wb_link;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [1:0]  pend_cnt;

    modport master (
        output wb_valid, wb_sel, wb_rd, wb_alu, wb_mem, wb_link,
        output mdu_valid, mdu_rd, mdu_data,
        input  mdu_ready, pipe_stall, rf_we, rf_wa, rf_wd, pend_cnt
    );

    modport slave (
        input  wb_valid, wb_sel, wb_rd, wb_alu, wb_mem, wb_link,
        input  mdu_valid, mdu_rd, mdu_data,
        output mdu_ready, pipe_stall, rf_we, rf_wa, rf_wd, pend_cnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline WB stage and a 2-deep MDU result FIFO.
// Optional macro WB_ZERO_FILTER_EN: grants targeting register 0 are consumed without writing.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst_n,
    wb_port_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]  cnt;
    logic [1:0]  cnt_nxt;
    logic [4:0]  rd0, rd1;
    logic [31:0] d0, d1;
    logic [3:0]  age;
    logic        stall;
    logic        push;
    logic        pop;
    logic        wr_hi;
    logic        g_we;
    logic [4:0]  g_rd;
    logic [31:0] g_data;

    assign stall         = (age == LIMIT);
    assign bus.pipe_stall = stall;
    assign bus.mdu_ready  = (cnt != 2'd2);
    assign bus.pend_cnt   = cnt;
    assign push          = bus.mdu_valid && (cnt != 2'd2);
    assign cnt_nxt       = cnt + {1'b0, push} - {1'b0, pop};
    // A push lands behind the head only when one entry stays resident this cycle.
    assign wr_hi         = (cnt == 2'd1) && !pop;

    always_comb begin
        pop    = 1'b0;
        g_we   = 1'b0;
        g_rd   = rd0;
        g_data = d0;
        if (stall) begin
            pop  = 1'b1;
            g_we = 1'b1;
        end else if (bus.wb_valid) begin
            g_rd = bus.wb_rd;
            case (bus.wb_sel)
                2'b00: begin g_we = 1'b1; g_data = bus.wb_alu;  end
                2'b01: begin g_we = 1'b1; g_data = bus.wb_mem;  end
                2'b10: begin g_we = 1'b1; g_data = bus.wb_link; end
                default: begin g_we = 1'b0; g_data = bus.wb_alu; end
            endcase
        end else if (cnt != 2'd0) begin
            pop  = 1'b1;
            g_we = 1'b1;
        end
`ifdef WB_ZERO_FILTER_EN
        if (g_rd == 5'd0) begin
            g_we = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
            rd0 <= 5'd0;
            rd1 <= 5'd0;
            d0  <= 32'd0;
            d1  <= 32'd0;
            age <= 4'd0;
        end else begin
            cnt <= cnt_nxt;
            if (pop) begin
                rd0 <= rd1;
                d0  <= d1;
            end
            if (push) begin
                if (wr_hi) begin
                    rd1 <= bus.mdu_rd;
                    d1  <= bus.mdu_data;
                end else begin
                    rd0 <= bus.mdu_rd;
                    d0  <= bus.mdu_data;
                end
            end
            if (pop || cnt == 2'd0) begin
                age <= 4'd0;
            end else if (age != LIMIT) begin
                age <= age + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_we <= 1'b0;
            bus.rf_wa <= 5'd0;
            bus.rf_wd <= 32'd0;
        end else begin
            bus.rf_we <= g_we;
            if (g_we) begin
                bus.rf_wa <= g_rd;
                bus.rf_wd <= g_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench for wb_port_arbiter with STARVE_LIMIT=4.
module tb_wb_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic wv, input logic [1:0] ws, input logic [4:0] wr,
                                 input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] link,
                                 input logic mv, input logic [4:0] mr, input logic [31:0] md);
        bus.wb_valid  = wv;
        bus.wb_sel    = ws;
        bus.wb_rd     = wr;
        bus.wb_alu    = alu;
        bus.wb_mem    = mem;
        bus.wb_link   = link;
        bus.mdu_valid = mv;
        bus.mdu_rd    = mr;
        bus.mdu_data  = md;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'b11, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        idle();
        #12;
        checkOutput("rst_rf_we", bus.rf_we, 0);
        checkOutput("rst_rf_wa", bus.rf_wa, 0);
        checkOutput("rst_rf_wd", bus.rf_wd, 0);
        checkOutput("rst_pend", bus.pend_cnt, 0);
        checkOutput("rst_stall", bus.pipe_stall, 0);
        checkOutput("rst_ready", bus.mdu_ready, 1);
        rst_n = 1'b1;
        step();

        // Pipeline source selection, including the no-write select.
        applyStimulus(1'b1, 2'b10, 5'd31, 32'h1, 32'h2, 32'h0000_0104, 1'b0, 5'd0, 32'd0);
        step();
        checkOutput("link_we", bus.rf_we, 1);
        checkOutput("link_wa", bus.rf_wa, 31);
        checkOutput("link_wd", bus.rf_wd, 32'h0000_0104);
        applyStimulus(1'b1, 2'b00, 5'd3, 32'h1111, 32'h2222, 32'h3333, 1'b0, 5'd0, 32'd0);
        step();
        checkOutput("alu_wa", bus.rf_wa, 3);
        checkOutput("alu_wd", bus.rf_wd, 32'h1111);
        applyStimulus(1'b1, 2'b01, 5'd4, 32'h1111, 32'h2222, 32'h3333, 1'b0, 5'd0, 32'd0);
        step();
        checkOutput("mem_wa", bus.rf_wa, 4);
        checkOutput("mem_wd", bus.rf_wd, 32'h2222);
        applyStimulus(1'b1, 2'b11, 5'd7, 32'h1111, 32'h2222, 32'h3333, 1'b0, 5'd0, 32'd0);
        step();
        checkOutput("nowr_we", bus.rf_we, 0);
        checkOutput("nowr_wa_hold", bus.rf_wa, 4);
        checkOutput("nowr_wd_hold", bus.rf_wd, 32'h2222);
        idle();
        step();
        checkOutput("idle_we", bus.rf_we, 0);

        // Single MDU result with an idle pipeline: written two cycles after the push.
        applyStimulus(1'b0, 2'b11, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        checkOutput("mdu1_pend", bus.pend_cnt, 1);
        checkOutput("mdu1_we_early", bus.rf_we, 0);
        idle();
        step();
        checkOutput("mdu1_we", bus.rf_we, 1);
        checkOutput("mdu1_wa", bus.rf_wa, 5);
        checkOutput("mdu1_wd", bus.rf_wd, 32'hDEAD_BEEF);
        checkOutput("mdu1_pend0", bus.pend_cnt, 0);

        // Starvation: continuous pipeline traffic, one pending result, stall after age reaches 4.
        applyStimulus(1'b1, 2'b00, 5'd10, 32'd100, 32'd0, 32'd0, 1'b1, 5'd6, 32'h600);
        step();
        checkOutput("starve_wa0", bus.rf_wa, 10);
        checkOutput("starve_stall0", bus.pipe_stall, 0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 2'b00, 5'(10 + i), 32'(100 + i), 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            step();
            checkOutput($sformatf("starve_wa%0d", i), bus.rf_wa, 32'(10 + i));
            checkOutput($sformatf("starve_stall%0d", i), bus.pipe_stall, (i == 4) ? 1 : 0);
        end
        applyStimulus(1'b1, 2'b00, 5'd15, 32'd105, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        checkOutput("starve_mdu_wa", bus.rf_wa, 6);
        checkOutput("starve_mdu_wd", bus.rf_wd, 32'h600);
        checkOutput("starve_stall_off", bus.pipe_stall, 0);
        step();
        checkOutput("starve_resume_wa", bus.rf_wa, 15);
        checkOutput("starve_resume_wd", bus.rf_wd, 105);

        // Three back-to-back MDU results under pipeline traffic; FIFO fills then drains in order.
        applyStimulus(1'b1, 2'b00, 5'd16, 32'h16, 32'd0, 32'd0, 1'b1, 5'd21, 32'h2100);
        checkOutput("bb_ready1", bus.mdu_ready, 1);
        step();
        applyStimulus(1'b1, 2'b00, 5'd16, 32'h16, 32'd0, 32'd0, 1'b1, 5'd22, 32'h2200);
        checkOutput("bb_ready2", bus.mdu_ready, 1);
        step();
        applyStimulus(1'b1, 2'b00, 5'd16, 32'h16, 32'd0, 32'd0, 1'b1, 5'd23, 32'h2300);
        checkOutput("bb_pend2", bus.pend_cnt, 2);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bb_ready0_%0d", i), bus.mdu_ready, 0);
            step();
        end
        checkOutput("bb_stall", bus.pipe_stall, 1);
        step();
        checkOutput("bb_first_wa", bus.rf_wa, 21);
        checkOutput("bb_first_wd", bus.rf_wd, 32'h2100);
        checkOutput("bb_ready_again", bus.mdu_ready, 1);
        step();
        checkOutput("bb_pipe_wa", bus.rf_wa, 16);
        checkOutput("bb_pend_full", bus.pend_cnt, 2);
        idle();
        step();
        checkOutput("bb_second_wa", bus.rf_wa, 22);
        checkOutput("bb_second_wd", bus.rf_wd, 32'h2200);
        step();
        checkOutput("bb_third_wa", bus.rf_wa, 23);
        checkOutput("bb_third_wd", bus.rf_wd, 32'h2300);
        checkOutput("bb_pend_empty", bus.pend_cnt, 0);

        // Asynchronous reset with two buffered results discards them.
        applyStimulus(1'b1, 2'b00, 5'd17, 32'h1700, 32'd0, 32'd0, 1'b1, 5'd24, 32'h2400);
        step();
        applyStimulus(1'b1, 2'b00, 5'd17, 32'h1700, 32'd0, 32'd0, 1'b1, 5'd25, 32'h2500);
        step();
        checkOutput("rst2_pre_pend", bus.pend_cnt, 2);
        checkOutput("rst2_pre_we", bus.rf_we, 1);
        idle();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst2_pend", bus.pend_cnt, 0);
        checkOutput("rst2_we", bus.rf_we, 0);
        checkOutput("rst2_stall", bus.pipe_stall, 0);
        checkOutput("rst2_ready", bus.mdu_ready, 1);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("rst2_after_we%0d", i), bus.rf_we, 0);
        end
        checkOutput("rst2_after_wa", bus.rf_wa, 0);

        // Destination register 0.
        applyStimulus(1'b1, 2'b00, 5'd0, 32'h55, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
`ifdef WB_ZERO_FILTER_EN
        checkOutput("zero_we", bus.rf_we, 0);
        checkOutput("zero_wd_hold", bus.rf_wd, 0);
`else
        checkOutput("zero_we", bus.rf_we, 1);
        checkOutput("zero_wa", bus.rf_wa, 0);
        checkOutput("zero_wd", bus.rf_wd, 32'h55);
`endif
        applyStimulus(1'b1, 2'b00, 5'd9, 32'h99, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        checkOutput("zero_next_wa", bus.rf_wa, 9);
        checkOutput("zero_next_wd", bus.rf_wd, 32'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, cycles a pending MDU result may wait before the pipeline is stalled (legal 1..15).
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Rst  in  1  reset, asynchronous, active-low.
REQ-004 wb_valid  in  1  pipeline WB stage holds an instruction needing a register write.
REQ-005 wb_sel  in  2  pipeline source select: 00 ALU result, 01 load data, 10 PC+4 link, 11 no write.
REQ-006 wb_rd  in  5  pipeline destination register.
REQ-007 wb_alu, wb_mem, wb_link  in  32 each  pipeline candidate write data.
REQ-008 mdu_valid  in  1  multi-cycle unit offers a result.
REQ-009 mdu_rd  in  5  MDU destination register.
REQ-010 mdu_data  in  32  MDU result.
REQ-011 mdu_ready  out  1  MDU result accepted this cycle when high with mdu_valid.
REQ-012 pipe_stall  out  1  pipeline WB stage must hold its current request.
REQ-013 rf_we  out  1  register-file write enable (registered).
REQ-014 rf_wa  out  5  register-file write address (registered).
REQ-015 rf_wd  out  32  register-file write data (registered).
REQ-016 pend_cnt  out  2  number of MDU results buffered (0..2).

Function
REQ-017 The block SHALL buffer MDU results in a 2-entry FIFO (rd+data), in arrival order.
REQ-018 mdu_ready SHALL equal (pend_cnt != 2), computed from registered count only; push occurs when mdu_valid && mdu_ready.
REQ-019 Push and pop in the same cycle SHALL leave pend_cnt unchanged and preserve order; push into empty FIFO SHALL NOT be poppable until the next cycle.
REQ-020 Grant per cycle: if pipe_stall=1, FIFO head; else if wb_valid=1, pipeline; else if FIFO non-empty, FIFO head; else none.
REQ-021 A pipeline grant SHALL select data by wb_sel (00 wb_alu, 01 wb_mem, 10 wb_link); wb_sel=11 SHALL be consumed with no write.
REQ-022 The granted write SHALL appear on rf_we/rf_wa/rf_wd on the cycle after the grant (latency 1); with no grant rf_we SHALL be 0 and rf_wa/rf_wd SHALL hold.
REQ-023 An age counter SHALL reset to 0 on any FIFO pop or when FIFO empty, else increment, saturating at STARVE_LIMIT.
REQ-024 pipe_stall SHALL be (age == STARVE_LIMIT); a stall cycle always pops the head, so pipe_stall lasts exactly one cycle per starvation event.
REQ-025 While pipe_stall=1 the pipeline request SHALL NOT be consumed; it SHALL be granted the following cycle if still valid.
REQ-026 Same rd from pipeline and MDU SHALL be written in grant order; no merging or reordering.

Reset
REQ-027 On Rst low: FIFO empty, pend_cnt=0, age=0, rf_we=0, rf_wa=0, rf_wd=0, pipe_stall=0, mdu_ready=1, asynchronously.
REQ-028 Reset mid-operation SHALL discard buffered MDU results and any write in flight.

Configuration
REQ-029 Macro WB_ZERO_FILTER_EN: when defined, any grant with destination 0 SHALL be consumed (FIFO pop / pipeline accept) with rf_we=0; when undefined, writes to register 0 SHALL be issued as any other.

Verification
REQ-030 wb_valid=1, wb_sel=10, wb_rd=31, wb_link=0x0000_0104 -> next cycle rf_we=1, rf_wa=31, rf_wd=0x0000_0104.
REQ-031 wb_valid=0, one MDU push rd=5 data=0xDEAD_BEEF -> pend_cnt=1, write rd=5 two cycles after push, pend_cnt back to 0.
REQ-032 wb_valid held 1 continuously, one MDU push, STARVE_LIMIT=4 -> pipe_stall high exactly one cycle when age=4, MDU write follows, pipeline resumes next cycle with no lost request.
REQ-033 Three back-to-back MDU pushes under continuous pipeline traffic -> third sees mdu_ready=0 after pend_cnt=2; results written in arrival order.
REQ-034 Rst pulsed low with pend_cnt=2 -> pend_cnt=0, rf_we=0, pipe_stall=0 immediately; no buffered result written afterwards.
REQ-035 WB_ZERO_FILTER_EN defined, wb_sel=00, wb_rd=0 -> rf_we stays 0, request consumed; undefined -> rf_we=1, rf_wa=0.
